// File: rtl/match_sequencer.sv
// Match flow controller for a two-player paddle game: serve, rally, pause, scoring and game over.
// Optional build macro MATCH_WIN_BY_TWO_EN requires a two-point lead to win (a point from 99 always wins).
module match_sequencer #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_TICKS = 50
) (
  input  logic       clk100Hz,
  input  logic       reset,
  input  logic       p1_ready,
  input  logic       p2_ready,
  input  logic       pause_sw,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic [1:0] rnd_dir,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       serve_load,
  output logic       serve_dx_neg,
  output logic       serve_dy_neg,
  output logic [3:0] s1_tens,
  output logic [3:0] s1_ones,
  output logic [3:0] s2_tens,
  output logic [3:0] s2_ones,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    RALLY  = 3'b001,
    PAUSED = 3'b010,
    OVER   = 3'b011,
    SERVE  = 3'b100
  } state_t;

  localparam logic [6:0] WIN7      = 7'(WIN_SCORE);
  localparam logic [6:0] MAX_SCORE = 7'd99;
  localparam logic [7:0] TICKS_M1  = 8'(SERVE_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic [1:0] win_q, win_d;
  logic       load_q, load_d;
  logic       dx_q, dx_d, dy_q, dy_d;

  logic [6:0] inc1, inc2;
  logic       win1, win2;
  logic       enter_serve;

  assign inc1 = (sc1_q == MAX_SCORE) ? MAX_SCORE : sc1_q + 7'd1;
  assign inc2 = (sc2_q == MAX_SCORE) ? MAX_SCORE : sc2_q + 7'd1;

`ifdef MATCH_WIN_BY_TWO_EN
  logic signed [7:0] lead1, lead2;
  assign lead1 = $signed({1'b0, inc1}) - $signed({1'b0, sc2_q});
  assign lead2 = $signed({1'b0, inc2}) - $signed({1'b0, sc1_q});
  // Saturation freezes the lead at 99, so any point scored from 99 decides the game.
  assign win1  = (inc1 >= WIN7) && ((lead1 >= 8'sd2) || (sc1_q == MAX_SCORE));
  assign win2  = (inc2 >= WIN7) && ((lead2 >= 8'sd2) || (sc2_q == MAX_SCORE));
`else
  assign win1  = (inc1 >= WIN7);
  assign win2  = (inc2 >= WIN7);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sc1_d       = sc1_q;
    sc2_d       = sc2_q;
    win_d       = win_q;
    load_d      = 1'b0;
    dx_d        = dx_q;
    dy_d        = dy_q;
    enter_serve = 1'b0;

    unique case (state_q)
      IDLE: if (p1_ready && p2_ready) enter_serve = 1'b1;
      SERVE: begin
        if (cnt_q == TICKS_M1) begin
          state_d = RALLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RALLY: begin
        if (point_p1) begin
          sc1_d = inc1;
          if (win1) begin
            state_d = OVER;
            win_d   = 2'b01;
          end else begin
            enter_serve = 1'b1;
          end
        end else if (point_p2) begin
          sc2_d = inc2;
          if (win2) begin
            state_d = OVER;
            win_d   = 2'b10;
          end else begin
            enter_serve = 1'b1;
          end
        end else if (pause_sw) begin
          state_d = PAUSED;
        end
      end
      PAUSED: if (!pause_sw) state_d = RALLY;
      OVER: begin
        if (p1_ready && p2_ready) begin
          state_d = IDLE;
          sc1_d   = '0;
          sc2_d   = '0;
          win_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Direction is latched on the entry edge so it is valid alongside serve_load.
    if (enter_serve) begin
      state_d = SERVE;
      cnt_d   = '0;
      load_d  = 1'b1;
      dx_d    = rnd_dir[0];
      dy_d    = rnd_dir[1];
    end
  end

  always_ff @(posedge clk100Hz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sc1_q   <= '0;
      sc2_q   <= '0;
      win_q   <= '0;
      load_q  <= 1'b0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      win_q   <= win_d;
      load_q  <= load_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign state        = state_q;
  assign ball_run     = (state_q == RALLY);
  assign serve_load   = load_q;
  assign serve_dx_neg = dx_q;
  assign serve_dy_neg = dy_q;
  assign winner       = win_q;
  assign s1_tens      = 4'(sc1_q / 7'd10);
  assign s1_ones      = 4'(sc1_q % 7'd10);
  assign s2_tens      = 4'(sc2_q / 7'd10);
  assign s2_ones      = 4'(sc2_q % 7'd10);

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 11: points needed to win, range 1..99.
REQ-002 SHALL have parameter SERVE_TICKS, default 50: number of clk100Hz cycles spent in SERVE before RALLY, range 1..255.
REQ-003 clk100Hz  in  1  game tick clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 p1_ready  in  1  player 1 ready request, active-high level.
REQ-006 p2_ready  in  1  player 2 ready request, active-high level.
REQ-007 pause_sw  in  1  pause request, active-high level.
REQ-008 point_p1  in  1  one-cycle pulse from the ball datapath; player 1 scored.
REQ-009 point_p2  in  1  one-cycle pulse from the ball datapath; player 2 scored.
REQ-010 rnd_dir  in  2  free-running random bits; bit0 selects the x serve direction, bit1 selects the y serve direction.
REQ-011 state  out  3  current state: IDLE=000, RALLY=001, PAUSED=010, OVER=011, SERVE=100.
REQ-012 ball_run  out  1  high only in RALLY; enables ball and paddle motion.
REQ-013 serve_load  out  1  one-cycle pulse; datapath reloads the centre ball position and initial speeds.
REQ-014 serve_dx_neg, serve_dy_neg  out  1 each  serve direction, latched on serve_load.
REQ-015 s1_tens, s1_ones, s2_tens, s2_ones  out  4 each  BCD scores, 0..9 per digit.
REQ-016 winner  out  2  00 none, 01 player 1, 10 player 2.

Function
REQ-017 IDLE: SHALL go to SERVE when p1_ready=1 and p2_ready=1 in the same cycle.
REQ-018 Entering SERVE: SHALL assert serve_load for exactly the first SERVE cycle; serve_dx_neg<=rnd_dir[0] and serve_dy_neg<=rnd_dir[1] on that cycle.
REQ-019 SERVE: SHALL hold for SERVE_TICKS cycles, counted from the entry cycle, then enter RALLY; pause_sw and point inputs are ignored.
REQ-020 RALLY: pause_sw=1 SHALL take the FSM to PAUSED on the next edge, with scores unchanged.
REQ-021 PAUSED: SHALL return to RALLY on the first cycle with pause_sw=0; ball_run=0 while paused.
REQ-022 RALLY point: a point_p1 or point_p2 pulse SHALL increment that player's score by 1 in BCD (ones 9 -> 0 with tens+1); scores saturate at 99.
REQ-023 point_p1 and point_p2 in the same cycle: SHALL credit player 1 only.
REQ-024 A point pulse in RALLY has priority over pause_sw in the same cycle.
REQ-025 After a point: if the win condition holds on the new score, SHALL enter OVER and set winner; otherwise SHALL enter SERVE.
REQ-026 Point pulses outside RALLY SHALL be ignored.
REQ-027 Win condition (base build): scorer's new score >= WIN_SCORE.
REQ-028 OVER: ball_run=0; scores and winner held; SHALL go to IDLE when p1_ready=1 and p2_ready=1.
REQ-029 On OVER -> IDLE, SHALL clear the scores and winner.
REQ-030 Internal scores SHALL be 7-bit binary, with BCD digits derived from them; the comparison with WIN_SCORE is done in binary.

Reset
REQ-031 reset=1 SHALL force, on the next edge, state=IDLE, all scores 0, winner=00, ball_run=0, serve_load=0, serve_dx_neg=0, serve_dy_neg=0, and the serve counter 0.
REQ-032 reset SHALL take priority over every other input in every state, including mid-SERVE and PAUSED.

Configuration
REQ-033 Macro MATCH_WIN_BY_TWO_EN defined: the win condition additionally requires scorer's score - opponent's score >= 2; 99 saturation still applies, and at 99-98 the next point to the leader wins.
REQ-034 Macro MATCH_WIN_BY_TWO_EN undefined: the REQ-027 rule only; no subtractor is instantiated.

Verification
REQ-035 Reset, then p1_ready=p2_ready=1 for 1 cycle -> state 100 next cycle, serve_load pulse 1 cycle, RALLY after 50 cycles.
REQ-036 In RALLY, 12 point_p1 pulses with serves between, base build -> s1 reaches 1/1 (11), state 011, winner=01; 12th pulse ignored.
REQ-037 point_p1 and point_p2 in the same cycle with score 3-4 -> 4-4, state SERVE.
REQ-038 pause_sw=1 in RALLY -> PAUSED, ball_run=0; point_p2 while paused -> score unchanged; pause_sw=0 -> RALLY.
REQ-039 MATCH_WIN_BY_TWO_EN defined, 10-10 then p1 point -> 11-10 SERVE; next p1 point -> 12-10 OVER, winner=01.
REQ-040 reset asserted in the 20th SERVE cycle at 5-3 -> IDLE, scores 0-0, serve_load=0.
